// File: rtl/adder_fixed_int16.sv
// Saturating sign-magnitude fixed-point adder with a registered result,
// valid strobe and saturation flag. One operation per clock, one-cycle latency.
module adder_fixed_int16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic [WIDTH-1:0] result_out,
    output logic             valid_out,
    output logic             sat_out
);

    localparam int unsigned MW = WIDTH - 1;

    logic          sign_a, sign_b;
    logic [MW-1:0] mag_a, mag_b;
    logic [MW:0]   mag_sum;
    logic [MW-1:0] mag_res;
    logic          sign_res;
    logic          sat_res;
    logic [WIDTH-1:0] result_d;

    assign sign_a  = A_in[WIDTH-1];
    assign sign_b  = B_in[WIDTH-1];
    assign mag_a   = A_in[MW-1:0];
    assign mag_b   = B_in[MW-1:0];
    assign mag_sum = {1'b0, mag_a} + {1'b0, mag_b};

    always_comb begin
        mag_res  = '0;
        sign_res = 1'b0;
        sat_res  = 1'b0;
        if (sign_a == sign_b) begin
            sign_res = sign_a;
            if (mag_sum[MW]) begin
                mag_res = {MW{1'b1}};
                sat_res = 1'b1;
            end else begin
                mag_res = mag_sum[MW-1:0];
            end
        end else if (mag_a > mag_b) begin
            mag_res  = mag_a - mag_b;
            sign_res = sign_a;
        end else if (mag_b > mag_a) begin
            mag_res  = mag_b - mag_a;
            sign_res = sign_b;
        end
        // Zero magnitude is always emitted as +0, including -0 + -0.
        result_d = {sign_res & (mag_res != '0), mag_res};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            result_out <= '0;
            valid_out  <= 1'b0;
            sat_out    <= 1'b0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                result_out <= result_d;
                sat_out    <= sat_res;
            end
        end
    end

endmodule

// File: tb/tb_adder_fixed_int16.sv
// Self-checking bench for adder_fixed_int16: directed corner cases, async reset,
// streaming and randomized traffic against a signed-integer reference model.
module tb_adder_fixed_int16;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        valid_in;
    logic [15:0] A_in, B_in;
    logic [15:0] result_out;
    logic        valid_out;
    logic        sat_out;

    int checks = 0;
    int failures = 0;

    logic [15:0] exp_res;
    logic        exp_sat;
    logic        exp_valid;

    adder_fixed_int16 #(.WIDTH(16)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .valid_in   (valid_in),
        .A_in       (A_in),
        .B_in       (B_in),
        .result_out (result_out),
        .valid_out  (valid_out),
        .sat_out    (sat_out)
    );

    always #5 CLK = ~CLK;

    // Reference: convert to signed integers, add, clamp, convert back.
    function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        int va, vb, s, m;
        logic [15:0] r;
        logic sat;
        va = a[15] ? -int'(a[14:0]) : int'(a[14:0]);
        vb = b[15] ? -int'(b[14:0]) : int'(b[14:0]);
        s = va + vb;
        sat = 1'b0;
        if (s > 32767) begin
            r = 16'h7FFF; sat = 1'b1;
        end else if (s < -32767) begin
            r = 16'hFFFF; sat = 1'b1;
        end else begin
            m = (s < 0) ? -s : s;
            r = {(s < 0), m[14:0]};
        end
        return {sat, r};
    endfunction

    // Drive one cycle of stimulus and advance the expected-output state.
    task automatic step(input logic [15:0] a, input logic [15:0] b, input logic v);
        logic [16:0] e;
        @(negedge CLK);
        A_in = a; B_in = b; valid_in = v;
        @(posedge CLK);
        #1;
        exp_valid = v;
        if (v) begin
            e = ref_add(a, b);
            exp_res = e[15:0];
            exp_sat = e[16];
        end
    endtask

    task automatic test_reset();
        // Load a non-zero result, then pull reset mid-cycle.
        step(16'h4000, 16'h4000, 1'b1);
        #2;
        RST_N = 1'b0;
        #1;
        checks++;
        if (result_out !== 16'h0000 || valid_out !== 1'b0 || sat_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: got res=%h v=%b s=%b, want 0000/0/0",
                     result_out, valid_out, sat_out);
        end
        // Clock edges under reset with valid_in high must not load anything.
        step(16'h1234, 16'h0001, 1'b1);
        checks++;
        if (result_out !== 16'h0000 || valid_out !== 1'b0 || sat_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: got res=%h v=%b s=%b, want 0000/0/0",
                     result_out, valid_out, sat_out);
        end
        @(negedge CLK);
        valid_in = 1'b0;
        RST_N = 1'b1;
        exp_res = 16'h0000; exp_sat = 1'b0; exp_valid = 1'b0;
        step(16'h0001, 16'h0001, 1'b1);
        checks++;
        if (result_out !== 16'h0002 || valid_out !== 1'b1 || sat_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_op: got res=%h v=%b s=%b, want 0002/1/0",
                     result_out, valid_out, sat_out);
        end
    endtask

    task automatic test_directed();
        logic [15:0] va [12];
        logic [15:0] vb [12];
        logic [15:0] vr [12];
        logic        vs [12];
        va = '{16'h4000, 16'h2AAA, 16'hC000, 16'h0001, 16'hC000, 16'hA000,
               16'h2000, 16'h4000, 16'h3000, 16'h8000, 16'h8000, 16'h8001};
        vb = '{16'h4000, 16'h5555, 16'hC000, 16'h0001, 16'h2000, 16'h4000,
               16'hC000, 16'hA000, 16'hB000, 16'h0005, 16'h8000, 16'h8001};
        vr = '{16'h7FFF, 16'h7FFF, 16'hFFFF, 16'h0002, 16'hA000, 16'h2000,
               16'hA000, 16'h2000, 16'h0000, 16'h0005, 16'h0000, 16'h8002};
        vs = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 12; i++) begin
            step(va[i], vb[i], 1'b1);
            checks++;
            if (result_out !== vr[i] || sat_out !== vs[i] || valid_out !== 1'b1) begin
                failures++;
                $display("FAIL directed_%0d %h+%h: got res=%h s=%b v=%b, want %h/%b/1",
                         i, va[i], vb[i], result_out, sat_out, valid_out, vr[i], vs[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int seen;
        logic [15:0] held;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step(16'(i * 16'h0101), 16'(16'h8000 | (i * 3)), 1'b1);
            if (valid_out === 1'b1) seen++;
            checks++;
            if (result_out !== exp_res || sat_out !== exp_sat) begin
                failures++;
                $display("FAIL b2b_%0d: got res=%h s=%b, want %h/%b",
                         i, result_out, sat_out, exp_res, exp_sat);
            end
        end
        checks++;
        if (seen !== 8) begin
            failures++;
            $display("FAIL b2b_count: got %0d valid_out pulses, want 8", seen);
        end
        held = exp_res;
        for (int i = 0; i < 2; i++) begin
            step(16'h7FFF, 16'h7FFF, 1'b0);
            checks++;
            if (valid_out !== 1'b0 || result_out !== held || sat_out !== exp_sat) begin
                failures++;
                $display("FAIL gap_%0d: got v=%b res=%h s=%b, want 0/%h/%b",
                         i, valid_out, result_out, sat_out, held, exp_sat);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        logic v;
        for (int i = 0; i < 300; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 7) == 0) b = {~a[15], a[14:0]};
            if ($urandom_range(0, 7) == 0) a = {a[15], 15'h0};
            v = ($urandom_range(0, 3) != 0);
            step(a, b, v);
            checks++;
            if (valid_out !== exp_valid || result_out !== exp_res || sat_out !== exp_sat) begin
                failures++;
                $display("FAIL random_%0d %h+%h v=%b: got res=%h s=%b v=%b, want %h/%b/%b",
                         i, a, b, v, result_out, sat_out, valid_out,
                         exp_res, exp_sat, exp_valid);
            end
        end
    endtask

    initial begin
        RST_N = 1'b1;
        valid_in = 1'b0;
        A_in = '0;
        B_in = '0;
        exp_res = '0; exp_sat = 1'b0; exp_valid = 1'b0;
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if (result_out !== 16'h0000 || valid_out !== 1'b0 || sat_out !== 1'b0) begin
            failures++;
            $display("FAIL power_on_reset: got res=%h v=%b s=%b, want 0000/0/0",
                     result_out, valid_out, sat_out);
        end
        #10 RST_N = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
